// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the mul_seq multiply sequencer.
package mul_seq_pkg;

    localparam int unsigned OP_W  = 32;
    localparam int unsigned PP_W  = 48;
    localparam int unsigned RES_W = 64;

    localparam logic [31:0] DSP_CMD_U16X32 = 32'd2;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        FIX,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ACC_HOLD,
        ACC_LOAD,
        ACC_ADD_SH16,
        ACC_SUB_FIX
    } acc_op_t;

    // Turns an unsigned 32x32 product into the two's-complement one when subtracted.
    function automatic logic [RES_W-1:0] sign_fix(input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
        logic [RES_W-1:0] fa;
        logic [RES_W-1:0] fb;
        fa = a[OP_W-1] ? {b, 32'h0} : '0;
        fb = b[OP_W-1] ? {a, 32'h0} : '0;
        return fa + fb;
    endfunction

endpackage

// File: rtl/mul_seq_acc.sv
// 64-bit product accumulator: load, add partial product shifted by 16, signed correction.
module mul_seq_acc
    import mul_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  acc_op_t          op,
    input  logic [PP_W-1:0]  pp,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [RES_W-1:0] acc
);

    logic [RES_W-1:0] pp_ext;

    assign pp_ext = {16'h0, pp};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else begin
            unique case (op)
                ACC_HOLD:     acc <= acc;
                ACC_LOAD:     acc <= pp_ext;
                ACC_ADD_SH16: acc <= acc + (pp_ext << 16);
                ACC_SUB_FIX:  acc <= acc - sign_fix(a, b);
            endcase
        end
    end

endmodule

// File: rtl/mul_seq.sv
// Two-pass 32x32->64 multiply sequencer driving a 16x32 dsp array.
// Signed operand support is compiled in with MUL_SEQ_SIGNED_EN.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int unsigned PIPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_a,
    input  logic [OP_W-1:0]  req_b,
    input  logic             req_signed,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [RES_W-1:0] resp_result,
    output logic [31:0]      dsp_command,
    output logic [31:0]      dsp_in_1,
    output logic [31:0]      dsp_in_2,
    input  logic [63:0]      dsp_result
);

    localparam logic [1:0] PIPE_LAST = 2'(PIPE);

    state_t           state, state_n;
    logic [1:0]       cnt, cnt_n;
    logic [OP_W-1:0]  a_q, a_n;
    logic [OP_W-1:0]  b_q, b_n;
    logic             ready_n;
    logic             valid_n;
    logic [RES_W-1:0] result_n;
    logic [31:0]      in_1_n, in_2_n;
    acc_op_t          acc_op;
    logic [PP_W-1:0]  acc_pp;
    logic [RES_W-1:0] acc;
    logic             unused_bits;

`ifdef MUL_SEQ_SIGNED_EN
    logic sgn_q, sgn_n;
    assign unused_bits = ^dsp_result[63:48];
`else
    assign unused_bits = ^{req_signed, dsp_result[63:48]};
`endif

    mul_seq_acc u_acc (
        .clk   (clk),
        .reset (reset),
        .op    (acc_op),
        .pp    (acc_pp),
        .a     (a_q),
        .b     (b_q),
        .acc   (acc)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        a_n      = a_q;
        b_n      = b_q;
        ready_n  = req_ready;
        valid_n  = resp_valid;
        result_n = resp_result;
        in_1_n   = dsp_in_1;
        in_2_n   = dsp_in_2;
        acc_op   = ACC_HOLD;
        acc_pp   = '0;
`ifdef MUL_SEQ_SIGNED_EN
        sgn_n    = sgn_q;
`endif
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    a_n     = req_a;
                    b_n     = req_b;
`ifdef MUL_SEQ_SIGNED_EN
                    sgn_n   = req_signed;
`endif
                    acc_op  = ACC_LOAD;
                    in_1_n  = {16'h0, req_a[15:0]};
                    in_2_n  = req_b;
                    cnt_n   = '0;
                    ready_n = 1'b0;
                    state_n = LO;
                end
            end
            LO: begin
                if (cnt == PIPE_LAST) begin
                    acc_op  = ACC_LOAD;
                    acc_pp  = dsp_result[PP_W-1:0];
                    in_1_n  = {16'h0, a_q[31:16]};
                    cnt_n   = '0;
                    state_n = HI;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            HI: begin
                if (cnt == PIPE_LAST) begin
                    acc_op  = ACC_ADD_SH16;
                    acc_pp  = dsp_result[PP_W-1:0];
                    cnt_n   = '0;
`ifdef MUL_SEQ_SIGNED_EN
                    state_n = sgn_q ? FIX : DONE;
`else
                    state_n = DONE;
`endif
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
`ifdef MUL_SEQ_SIGNED_EN
            FIX: begin
                acc_op  = ACC_SUB_FIX;
                state_n = DONE;
            end
`endif
            DONE: begin
                // First DONE cycle captures the settled accumulator; later cycles wait for handshake.
                if (!resp_valid) begin
                    valid_n  = 1'b1;
                    result_n = acc;
                end else if (resp_ready) begin
                    valid_n = 1'b0;
                    in_1_n  = '0;
                    in_2_n  = '0;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                ready_n = 1'b1;
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            dsp_command <= DSP_CMD_U16X32;
            dsp_in_1    <= '0;
            dsp_in_2    <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            sgn_q       <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            a_q         <= a_n;
            b_q         <= b_n;
            req_ready   <= ready_n;
            resp_valid  <= valid_n;
            resp_result <= result_n;
            dsp_command <= DSP_CMD_U16X32;
            dsp_in_1    <= in_1_n;
            dsp_in_2    <= in_2_n;
`ifdef MUL_SEQ_SIGNED_EN
            sgn_q       <= sgn_n;
`endif
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: PIPE=0 and PIPE=2 instances behind a dsp model, scoreboard checked.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_signed;
    logic        resp_ready;

    logic        rdy0, rv0, rdy2, rv2;
    logic [63:0] res0, res2, dres0, dres2, p2a, p2b;
    logic [31:0] cmd0, cmd2, in1_0, in2_0, in1_2, in2_2;

    logic        rdy, rv;
    logic [63:0] res;
    logic [31:0] cmd, in1, in2;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    mul_seq #(.PIPE(0)) u0 (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid & ~sel),
        .req_ready   (rdy0),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_signed  (req_signed),
        .resp_valid  (rv0),
        .resp_ready  (resp_ready),
        .resp_result (res0),
        .dsp_command (cmd0),
        .dsp_in_1    (in1_0),
        .dsp_in_2    (in2_0),
        .dsp_result  (dres0)
    );

    mul_seq #(.PIPE(2)) u2 (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid & sel),
        .req_ready   (rdy2),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_signed  (req_signed),
        .resp_valid  (rv2),
        .resp_ready  (resp_ready),
        .resp_result (res2),
        .dsp_command (cmd2),
        .dsp_in_1    (in1_2),
        .dsp_in_2    (in2_2),
        .dsp_result  (dres2)
    );

    // dsp model: 16x32 unsigned product, junk in the unused upper bits
    assign dres0 = {16'hA5A5, 48'(in1_0[15:0]) * 48'(in2_0)};
    always @(posedge clk) begin
        p2a <= {16'h5A5A, 48'(in1_2[15:0]) * 48'(in2_2)};
        p2b <= p2a;
    end
    assign dres2 = p2b;

    assign rdy = sel ? rdy2 : rdy0;
    assign rv  = sel ? rv2  : rv0;
    assign res = sel ? res2 : res0;
    assign cmd = sel ? cmd2 : cmd0;
    assign in1 = sel ? in1_2 : in1_0;
    assign in2 = sel ? in2_2 : in2_0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_req_ready", 64'(rdy), 64'd1);
        check("rst_resp_valid", 64'(rv), 64'd0);
        check("rst_resp_result", res, 64'd0);
        check("rst_dsp_command", 64'(cmd), 64'd2);
        check("rst_dsp_in_1", 64'(in1), 64'd0);
        check("rst_dsp_in_2", 64'(in2), 64'd0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
        int lat;
        int pipe;
        int lat_exp;
        logic [63:0] exp;
        logic [63:0] held;
        pipe = sel ? 2 : 0;
`ifdef MUL_SEQ_SIGNED_EN
        if (s) exp = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else   exp = {32'h0, a} * {32'h0, b};
        lat_exp = 3 + 2 * pipe + (s ? 1 : 0);
`else
        exp = {32'h0, a} * {32'h0, b};
        lat_exp = 3 + 2 * pipe;
`endif
        sb.push_back(exp);
        @(negedge clk);
        req_a = a; req_b = b; req_signed = s; req_valid = 1'b1;
        check("req_ready_idle", 64'(rdy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        // with backpressure tests, keep a different request pending to show it is ignored
        if (hold > 0) begin
            req_a = ~a; req_b = ~b;
        end else begin
            req_valid = 1'b0;
        end
        lat = 0;
        while (!rv && lat < 100) begin
            if (lat == 0) begin
                check("dsp_in_1_lo", 64'(in1), {48'h0, a[15:0]});
                check("dsp_in_2_lo", 64'(in2), {32'h0, b});
                check("req_ready_busy", 64'(rdy), 64'd0);
            end
            if (lat == 1 + pipe) check("dsp_in_1_hi", 64'(in1), {48'h0, a[31:16]});
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", 64'(lat), 64'(lat_exp));
        check("resp_result", res, (sb.size() > 0) ? sb.pop_front() : 64'hx);
        held = res;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_resp_valid", 64'(rv), 64'd1);
            check("bp_resp_result", res, held);
            check("bp_req_ready", 64'(rdy), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("post_hs_resp_valid", 64'(rv), 64'd0);
        check("post_hs_req_ready", 64'(rdy), 64'd1);
        check("post_hs_dsp_in_1", 64'(in1), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; reset = 1'b1; req_valid = 1'b0;
        req_a = '0; req_b = '0; req_signed = 1'b0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state();
        sel = 1'b1;
        #1;
        check_reset_state();
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'h0001_2345, 32'h0000_0010, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 0);
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5);

        // abort during HI
        @(negedge clk);
        req_a = 32'd7; req_b = 32'd9; req_signed = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("abort_resp_valid", 64'(rv), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_req_ready", 64'(rdy), 64'd1);
        do_op(32'h0000_0003, 32'h0000_0005, 1'b0, 0);

        sel = 1'b1;
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        check("pipe2_dsp_command", 64'(cmd), 64'd2);
        do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 2);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
